scan_chain_ctrl: RTL



---
 rtl/scan_pkg.sv | 17 +
 rtl/scan_shreg.sv | 38 +++
 rtl/scan_chain_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/scan_pkg.sv
// Shared types for the scan load/capture/unload controller.
package scan_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    CAPTURE = 3'd2,
    UNLOAD  = 3'd3,
    DONE_ST = 3'd4
  } state_t;

  // Counter must hold 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/scan_shreg.sv
// N-bit shift register with parallel load and serial input, shifting toward the MSB.
module scan_shreg
  import scan_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift_en,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = load_val;
    end else if (shift_en) begin
      data_d = {data_q[WIDTH-2:0], sin};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan controller: shifts a pattern into one chain, pulses capture, unloads the
// response and compares it against an expected value under a mask.
module scan_chain_ctrl
  import scan_pkg::*;
#(
  parameter  int CHAIN_LEN = 32,
  localparam int CNT_W     = cnt_width(CHAIN_LEN)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic [CHAIN_LEN-1:0] PAT_IN,
  input  logic [CHAIN_LEN-1:0] EXP_IN,
  input  logic [CHAIN_LEN-1:0] MASK_IN,
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 FAIL,
  output logic [CHAIN_LEN-1:0] RESP
);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 se_q, se_d;
  logic                 si_q, si_d;
  logic                 done_q, done_d;
  logic                 fail_q, fail_d;
  logic [CHAIN_LEN-1:0] resp_out_q, resp_out_d;
  logic [CHAIN_LEN-1:0] exp_q, exp_d;
  logic [CHAIN_LEN-1:0] mask_q, mask_d;

  logic                 pat_load;
  logic                 pat_shift;
  logic                 rsp_shift;
  logic                 last_cnt;
  logic [CHAIN_LEN-1:0] pat_q;
  logic [CHAIN_LEN-1:0] rsp_q;

  // PAT_IN[N-1] goes straight to SI on the accept edge, so the register starts one bit ahead.
  scan_shreg #(.WIDTH(CHAIN_LEN)) u_pat (
    .clk      (CLK),
    .rst      (RST),
    .load     (pat_load),
    .load_val ({PAT_IN[CHAIN_LEN-2:0], 1'b0}),
    .shift_en (pat_shift),
    .sin      (1'b0),
    .q        (pat_q)
  );

  scan_shreg #(.WIDTH(CHAIN_LEN)) u_rsp (
    .clk      (CLK),
    .rst      (RST),
    .load     (pat_load),
    .load_val ('0),
    .shift_en (rsp_shift),
    .sin      (SO),
    .q        (rsp_q)
  );

  assign last_cnt = (cnt_q == CNT_W'(CHAIN_LEN - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    se_d       = 1'b0;
    si_d       = 1'b0;
    done_d     = 1'b0;
    fail_d     = fail_q;
    resp_out_d = resp_out_q;
    exp_d      = exp_q;
    mask_d     = mask_q;
    pat_load   = 1'b0;
    pat_shift  = 1'b0;
    rsp_shift  = 1'b0;

    case (state_q)
      IDLE: begin
        if (START && !ABORT) begin
          state_d  = SHIFT;
          cnt_d    = '0;
          pat_load = 1'b1;
          exp_d    = EXP_IN;
          mask_d   = MASK_IN;
          se_d     = 1'b1;
          si_d     = PAT_IN[CHAIN_LEN-1];
        end
      end
      SHIFT: begin
        pat_shift = 1'b1;
        if (last_cnt) begin
          state_d = CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          se_d  = 1'b1;
          si_d  = pat_q[CHAIN_LEN-1];
        end
      end
      CAPTURE: begin
        state_d = UNLOAD;
        cnt_d   = '0;
        se_d    = 1'b1;
      end
      UNLOAD: begin
        rsp_shift = 1'b1;
        if (last_cnt) begin
          state_d = DONE_ST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          se_d  = 1'b1;
        end
      end
      DONE_ST: begin
        state_d    = IDLE;
        done_d     = 1'b1;
        resp_out_d = rsp_q;
        fail_d     = |((rsp_q ^ exp_q) & mask_q);
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Abort drops the run without touching the last reported result.
    if (ABORT && (state_q != IDLE)) begin
      state_d    = IDLE;
      cnt_d      = '0;
      se_d       = 1'b0;
      si_d       = 1'b0;
      done_d     = 1'b0;
      fail_d     = fail_q;
      resp_out_d = resp_out_q;
      pat_shift  = 1'b0;
      rsp_shift  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      se_q       <= 1'b0;
      si_q       <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      resp_out_q <= '0;
      exp_q      <= '0;
      mask_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      se_q       <= se_d;
      si_q       <= si_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
      resp_out_q <= resp_out_d;
      exp_q      <= exp_d;
      mask_q     <= mask_d;
    end
  end

  assign SE   = se_q;
  assign SI   = si_q;
  assign BUSY = (state_q == SHIFT) || (state_q == CAPTURE) || (state_q == UNLOAD);
  assign DONE = done_q;
  assign FAIL = fail_q;
  assign RESP = resp_out_q;

endmodule
